// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and FILL read-order helper for the LBP fetch stage.
package lbp_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int AW    = 14;
    localparam int DW    = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        EMIT = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    // Window cell indices, row-major; G_C is the centre pixel.
    localparam int G_TL = 0;
    localparam int G_T  = 1;
    localparam int G_TR = 2;
    localparam int G_L  = 3;
    localparam int G_C  = 4;
    localparam int G_R  = 5;
    localparam int G_BL = 6;
    localparam int G_B  = 7;
    localparam int G_BR = 8;

    // FILL reads column-major: k=0..8 maps to {col_sel, row_sel}.
    function automatic logic [3:0] fill_sel(input logic [3:0] k);
        logic [1:0] col;
        logic [1:0] row;
        if (k < 4'd3) begin
            col = 2'd0;
            row = k[1:0];
        end else if (k < 4'd6) begin
            col = 2'd1;
            row = 2'(k - 4'd3);
        end else begin
            col = 2'd2;
            row = 2'(k - 4'd6);
        end
        return {col, row};
    endfunction

endpackage

// File: rtl/lbp_win_shift.sv
// 3x3 pixel window register array with a (row, column) write port and a
// left-shift used when the window slides one pixel to the right.
module lbp_win_shift #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [1:0]      i_row,
    input  logic [1:0]      i_col,
    input  logic [DW-1:0]   i_data,
    input  logic            i_shift,
    output logic [9*DW-1:0] o_win
);
    import lbp_pkg::*;

    localparam int NCELL = G_BR + 1;

    logic [DW-1:0] r_px [NCELL];
    logic [3:0]    w_idx;

    assign w_idx = ({2'b00, i_row} * 4'd3) + {2'b00, i_col};

    // Shift columns left on a slide, otherwise store one fetched pixel.
    always_ff @(posedge clk) begin
        if (i_shift) begin
            for (int rw = 0; rw < 3; rw++) begin
                r_px[rw*3]     <= r_px[rw*3 + 1];
                r_px[rw*3 + 1] <= r_px[rw*3 + 2];
            end
        end else if (i_we) begin
            for (int i = 0; i < NCELL; i++) begin
                if (w_idx == 4'(i)) begin
                    r_px[i] <= i_data;
                end
            end
        end
    end

    // Flatten the array, g_i at bits [DW*i +: DW].
    always_comb begin
        o_win = '0;
        for (int i = 0; i < NCELL; i++) begin
            o_win[DW*i +: DW] = r_px[i];
        end
    end

endmodule

// File: rtl/lbp_window_fetch.sv
// LBP fetch stage: walks every interior pixel row-major, reads its 3x3
// neighbourhood from the gray image (9 reads at row start, 3 per slide)
// and presents it over a valid/ready handshake.
module lbp_window_fetch #(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H,
    parameter int AW    = lbp_pkg::AW,
    parameter int DW    = lbp_pkg::DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            gray_ready,
    output logic            gray_req,
    output logic [AW-1:0]   gray_addr,
    input  logic [DW-1:0]   gray_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_data,
    output logic [AW-1:0]   win_addr,
    output logic            done
);
    import lbp_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = AW - CW;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 2);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 2);

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [3:0]    r_k;

    logic          w_fetch;
    logic          w_last;
    logic          w_accept;
    logic          w_shift;
    logic [3:0]    w_sel;
    logic [RW-1:0] w_rd_row;
    logic [CW-1:0] w_rd_col;
    logic [1:0]    w_wr_row;
    logic [1:0]    w_wr_col;
    logic [9*DW-1:0] w_win;

    assign w_fetch  = ((r_state == FILL) || (r_state == STEP)) && gray_ready;
    assign w_accept = (r_state == EMIT) && win_ready;
    assign w_shift  = w_accept && (r_col != C_LAST);

    // Read address and window write slot for the current FILL/STEP read.
    always_comb begin
        w_sel    = fill_sel(r_k);
        w_rd_row = r_row - R_ONE + RW'(r_k[1:0]);
        w_rd_col = r_col + C_ONE;
        w_wr_row = r_k[1:0];
        w_wr_col = 2'd2;
        w_last   = (r_k == 4'd2);
        if (r_state == FILL) begin
            w_rd_row = r_row - R_ONE + RW'(w_sel[1:0]);
            w_rd_col = r_col - C_ONE + CW'(w_sel[3:2]);
            w_wr_row = w_sel[1:0];
            w_wr_col = w_sel[3:2];
            w_last   = (r_k == 4'd8);
        end
    end

    // FSM plus centre row/column and read-index counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= R_ONE;
            r_col   <= C_ONE;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (gray_ready) begin
                        r_state <= FILL;
                        r_k     <= '0;
                    end
                end
                FILL, STEP: begin
                    if (w_fetch) begin
                        if (w_last) begin
                            r_k     <= '0;
                            r_state <= EMIT;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        if (r_col != C_LAST) begin
                            r_col   <= r_col + C_ONE;
                            r_state <= STEP;
                        end else if (r_row != R_LAST) begin
                            r_row   <= r_row + R_ONE;
                            r_col   <= C_ONE;
                            r_state <= FILL;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    lbp_win_shift #(
        .DW (DW)
    ) u_win (
        .clk     (clk),
        .i_we    (w_fetch),
        .i_row   (w_wr_row),
        .i_col   (w_wr_col),
        .i_data  (gray_data),
        .i_shift (w_shift),
        .o_win   (w_win)
    );

    // Window content is only exposed in EMIT, so a reset never leaks a partial window.
    assign gray_req  = w_fetch;
    assign gray_addr = w_fetch ? {w_rd_row, w_rd_col} : '0;
    assign win_valid = (r_state == EMIT);
    assign win_data  = win_valid ? w_win : '0;
    assign win_addr  = win_valid ? {r_row, r_col} : '0;
    assign done      = (r_state == DONE);

endmodule
